// File: rtl/bp_fe_bht_ctrl.sv
// Arbiter that sits in front of a branch history table. It walks an init over every
// entry, then shares the single BHT port between prediction reads and queued updates.
module bp_fe_bht_ctrl #(
    parameter int bht_idx_width_p = 10,
    parameter int fifo_els_p      = 4,
    parameter int starve_limit_p  = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       init_i,

    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       r_ready_o,
    output logic                       predict_v_o,
    output logic                       predict_o,

    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       correct_i,
    output logic                       w_ready_o,

    output logic                       bht_r_v_o,
    output logic                       bht_w_v_o,
    output logic                       bht_init_o,
    output logic [bht_idx_width_p-1:0] bht_idx_o,
    output logic                       bht_correct_o,
    input  logic                       bht_predict_i,

    output logic                       busy_o
);

    localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp    = ptr_w_lp + 1;
    localparam int starve_w_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
    localparam int ent_w_lp    = bht_idx_width_p + 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e                     state_q, state_d;
    logic [bht_idx_width_p-1:0] wcnt_q, wcnt_d;
    logic [ptr_w_lp-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]        rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]        count_q, count_d;
    logic [starve_w_lp-1:0]     starve_q, starve_d;

    logic [ent_w_lp-1:0]        mem_q [fifo_els_p];
    logic [ent_w_lp-1:0]        head;

    logic full, empty, starve_ok;
    logic grant, push, pop, flush;

    assign full      = (count_q == cnt_w_lp'(fifo_els_p));
    assign empty     = (count_q == '0);
    assign starve_ok = (starve_q < starve_w_lp'(starve_limit_p));
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        starve_d      = starve_q;
        grant         = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        busy_o        = 1'b0;
        r_ready_o     = 1'b0;
        w_ready_o     = 1'b0;
        bht_r_v_o     = 1'b0;
        bht_w_v_o     = 1'b0;
        bht_init_o    = 1'b0;
        bht_idx_o     = '0;
        bht_correct_o = 1'b0;

        case (state_q)
            S_INIT: begin
                busy_o = 1'b1;
                // The reset term keeps the init strobe quiet while reset is held.
                bht_init_o = reset_n_i;
                bht_idx_o  = wcnt_q;
                wcnt_d     = wcnt_q + bht_idx_width_p'(1);
                if (init_i) begin
                    wcnt_d = '0;
                end else if (wcnt_q == {bht_idx_width_p{1'b1}}) begin
                    state_d = S_RUN;
                end
            end

            default: begin
                w_ready_o = !full;
                push      = w_v_i && !full;
                grant     = r_v_i && (empty || (starve_ok && !full));
                // Entries about to be flushed by a re-init are never sent to the table.
                pop       = !grant && !empty && !init_i;

                if (grant) begin
                    r_ready_o = 1'b1;
                    bht_r_v_o = 1'b1;
                    bht_idx_o = idx_r_i;
                end else if (pop) begin
                    bht_w_v_o     = 1'b1;
                    bht_idx_o     = head[ent_w_lp-1:1];
                    bht_correct_o = head[0];
                end

                wr_ptr_d = wr_ptr_q + ptr_w_lp'(push);
                rd_ptr_d = rd_ptr_q + ptr_w_lp'(pop);
                count_d  = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);

                if (pop) begin
                    starve_d = '0;
                end else if (!empty && starve_ok) begin
                    starve_d = starve_q + starve_w_lp'(1);
                end

                if (init_i) begin
                    flush    = 1'b1;
                    state_d  = S_INIT;
                    wcnt_d   = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    starve_d = '0;
                end
            end
        endcase
    end

    assign predict_v_o = r_ready_o;
    assign predict_o   = bht_predict_i & r_ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_INIT;
            wcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= {idx_w_i, correct_i};
        end
    end

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Directed bench for bp_fe_bht_ctrl with an 8-entry table and a 4-deep update FIFO.
module tb_bp_fe_bht_ctrl;

    logic       clk;
    logic       reset_n;
    logic       init;
    logic       r_v;
    logic [2:0] idx_r;
    logic       r_ready;
    logic       predict_v;
    logic       predict;
    logic       w_v;
    logic [2:0] idx_w;
    logic       correct;
    logic       w_ready;
    logic       bht_r_v;
    logic       bht_w_v;
    logic       bht_init;
    logic [2:0] bht_idx;
    logic       bht_correct;
    logic       bht_predict;
    logic       busy;

    int n_chk;
    int n_fail;

    bp_fe_bht_ctrl #(
        .bht_idx_width_p(3),
        .fifo_els_p     (4),
        .starve_limit_p (3)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .init_i       (init),
        .r_v_i        (r_v),
        .idx_r_i      (idx_r),
        .r_ready_o    (r_ready),
        .predict_v_o  (predict_v),
        .predict_o    (predict),
        .w_v_i        (w_v),
        .idx_w_i      (idx_w),
        .correct_i    (correct),
        .w_ready_o    (w_ready),
        .bht_r_v_o    (bht_r_v),
        .bht_w_v_o    (bht_w_v),
        .bht_init_o   (bht_init),
        .bht_idx_o    (bht_idx),
        .bht_correct_o(bht_correct),
        .bht_predict_i(bht_predict),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_walk(input string tag);
        for (int i = 0; i < 8; i++) begin
            #1;
            check({tag, "_init"}, 32'(bht_init), 32'd1);
            check({tag, "_idx"}, 32'(bht_idx), 32'(i));
            check({tag, "_wrdy"}, 32'(w_ready), 32'd0);
            step();
        end
        #1;
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_init_done"}, 32'(bht_init), 32'd0);
    endtask

    task automatic check_pop(input string tag, input int idx, input int cor);
        check({tag, "_wv"}, 32'(bht_w_v), 32'd1);
        check({tag, "_idx"}, 32'(bht_idx), 32'(idx));
        check({tag, "_cor"}, 32'(bht_correct), 32'(cor));
        check({tag, "_rrdy"}, 32'(r_ready), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset_n = 1'b0;
        init = 1'b0;
        r_v = 1'b0;
        idx_r = 3'd0;
        w_v = 1'b0;
        idx_w = 3'd0;
        correct = 1'b0;
        bht_predict = 1'b0;

        // Reset values
        #2;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rrdy", 32'(r_ready), 32'd0);
        check("rst_wrdy", 32'(w_ready), 32'd0);
        check("rst_pv", 32'(predict_v), 32'd0);
        check("rst_rv", 32'(bht_r_v), 32'd0);
        check("rst_wv", 32'(bht_w_v), 32'd0);
        check("rst_init", 32'(bht_init), 32'd0);

        // Walk after release
        reset_n = 1'b1;
        check_walk("walk0");

        // Zero-latency read with empty FIFO
        r_v = 1'b1;
        idx_r = 3'd5;
        bht_predict = 1'b1;
        #1;
        check("rd_rrdy", 32'(r_ready), 32'd1);
        check("rd_rv", 32'(bht_r_v), 32'd1);
        check("rd_idx", 32'(bht_idx), 32'd5);
        check("rd_pv", 32'(predict_v), 32'd1);
        check("rd_p", 32'(predict), 32'd1);
        bht_predict = 1'b0;
        #1;
        check("rd_p0", 32'(predict), 32'd0);
        bht_predict = 1'b1;

        // One update starves for three reads then pops
        w_v = 1'b1;
        idx_w = 3'd2;
        correct = 1'b0;
        #1;
        check("st_push_wrdy", 32'(w_ready), 32'd1);
        check("st_push_rrdy", 32'(r_ready), 32'd1);
        step();
        w_v = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("st_read_rrdy", 32'(r_ready), 32'd1);
            check("st_read_wv", 32'(bht_w_v), 32'd0);
            step();
        end
        #1;
        check_pop("st_pop", 2, 0);
        check("st_pop_pv", 32'(predict_v), 32'd0);
        check("st_pop_rv", 32'(bht_r_v), 32'd0);
        step();
        #1;
        check("st_resume_rrdy", 32'(r_ready), 32'd1);
        check("st_resume_wv", 32'(bht_w_v), 32'd0);

        // Fill to four with reads winning, then full forces pops
        w_v = 1'b1;
        idx_w = 3'd1; correct = 1'b1; #1;
        check("fill1_wrdy", 32'(w_ready), 32'd1);
        check("fill1_rrdy", 32'(r_ready), 32'd1);
        step();
        idx_w = 3'd3; correct = 1'b0; #1;
        check("fill2_wrdy", 32'(w_ready), 32'd1);
        check("fill2_rrdy", 32'(r_ready), 32'd1);
        step();
        idx_w = 3'd4; correct = 1'b1; #1;
        check("fill3_wrdy", 32'(w_ready), 32'd1);
        check("fill3_rrdy", 32'(r_ready), 32'd1);
        step();
        idx_w = 3'd6; correct = 1'b1; #1;
        check("fill4_wrdy", 32'(w_ready), 32'd1);
        check("fill4_rrdy", 32'(r_ready), 32'd1);
        step();
        idx_w = 3'd7; correct = 1'b0; #1;
        check("full_wrdy", 32'(w_ready), 32'd0);
        check_pop("full_pop", 1, 1);
        step();
        w_v = 1'b0;
        #1;
        check("after_full_rrdy", 32'(r_ready), 32'd1);
        check("after_full_wrdy", 32'(w_ready), 32'd1);
        step();
        r_v = 1'b0;
        #1;
        check_pop("drain1", 3, 0);
        step(); #1;
        check_pop("drain2", 4, 1);
        step(); #1;
        check_pop("drain3", 6, 1);
        step(); #1;
        check("drained_wv", 32'(bht_w_v), 32'd0);
        check("drained_rv", 32'(bht_r_v), 32'd0);
        check("drained_init", 32'(bht_init), 32'd0);

        // Re-init with two entries queued
        r_v = 1'b1;
        w_v = 1'b1;
        idx_w = 3'd5; correct = 1'b1;
        step();
        idx_w = 3'd7; correct = 1'b0;
        step();
        w_v = 1'b0;
        r_v = 1'b0;
        init = 1'b1;
        #1;
        check("reinit_wv", 32'(bht_w_v), 32'd0);
        check("reinit_busy_now", 32'(busy), 32'd0);
        step();
        init = 1'b0;
        #1;
        check("reinit_busy", 32'(busy), 32'd1);
        check("reinit_rrdy", 32'(r_ready), 32'd0);
        check_walk("walk1");
        check("reinit_empty_wv", 32'(bht_w_v), 32'd0);
        check("reinit_empty_wrdy", 32'(w_ready), 32'd1);

        // init_i during the walk restarts it
        init = 1'b1;
        step();
        init = 1'b0;
        step(); step();
        init = 1'b1;
        #1;
        check("restart_idx_before", 32'(bht_idx), 32'd2);
        step();
        init = 1'b0;
        check_walk("walk2");

        // Async reset mid-walk at wcnt=4
        init = 1'b1;
        step();
        init = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1;
        check("mid_idx", 32'(bht_idx), 32'd4);
        reset_n = 1'b0;
        #1;
        check("arst_init", 32'(bht_init), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_rv", 32'(bht_r_v), 32'd0);
        check("arst_wv", 32'(bht_w_v), 32'd0);
        check("arst_pv", 32'(predict_v), 32'd0);
        step();
        reset_n = 1'b1;
        check_walk("walk3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
